// File: rtl/sdram_arb_pkg.sv
// Shared types for the two-master SDRAM port arbiter: FSM states, master ID
// type and the default outstanding-read depth.
package sdram_arb_pkg;

  typedef enum logic {
    ARB  = 1'b0,
    HOLD = 1'b1
  } arb_state_e;

  typedef logic id_t;

  localparam int MAX_PEND_DEF = 8;

endpackage

// File: rtl/owner_fifo.sv
// Ring buffer of master IDs for reads in flight at the SDRAM controller.
// The head is read combinationally so returning data can be routed in the same cycle.
module owner_fifo
  import sdram_arb_pkg::*;
#(
  parameter  int DEPTH = MAX_PEND_DEF,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  id_t           push_id_i,
  input  logic          pop_i,
  output id_t           head_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  id_t           mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // Simultaneous push and pop both take effect, leaving the count unchanged.
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push_ok);
    rd_ptr_d = rd_ptr_q + PW'(pop_ok);
    count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_id_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM SDRAM slave between the DNN master (m0)
// and the CPU/DMA master (m1); read data is routed back through an owner FIFO.
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter  int ADDR_W   = 24,
  parameter  int DATA_W   = 16,
  parameter  int MAX_PEND = MAX_PEND_DEF,
  localparam int BE_W     = DATA_W / 8,
  localparam int PEND_W   = $clog2(MAX_PEND) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  input  logic [BE_W-1:0]   m0_byteenable,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  input  logic [BE_W-1:0]   m1_byteenable,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] s_address,
  output logic              s_read,
  output logic              s_write,
  output logic [DATA_W-1:0] s_writedata,
  output logic [BE_W-1:0]   s_byteenable,
  input  logic              s_waitrequest,
  input  logic [DATA_W-1:0] s_readdata,
  input  logic              s_readdatavalid,
  output logic              err_orphan
);

  arb_state_e        state_q, state_d;
  id_t               last_q, last_d;
  id_t               hold_id_q, hold_id_d;
  logic              err_orphan_q, err_orphan_d;

  logic [1:0]        rd_v, wr_v, elig, wait_v, rdv_v;
  logic [ADDR_W-1:0] addr_a [2];
  logic [DATA_W-1:0] wdata_a [2];
  logic [BE_W-1:0]   be_a [2];

  logic              gnt_v, s_read_c, s_write_c, accept;
  id_t               gnt_id;
  id_t               fifo_head;
  logic              fifo_full, fifo_empty;
  logic [PEND_W-1:0] pend;

  // Read+write together is treated as a write.
  assign rd_v = {m1_read & ~m1_write, m0_read & ~m0_write};
  assign wr_v = {m1_write, m0_write};

  assign addr_a[0]  = m0_address;
  assign addr_a[1]  = m1_address;
  assign wdata_a[0] = m0_writedata;
  assign wdata_a[1] = m1_writedata;
  assign be_a[0]    = m0_byteenable;
  assign be_a[1]    = m1_byteenable;

  // A read cannot compete while the owner FIFO is full; writes still can.
  assign elig = wr_v | (rd_v & {2{~fifo_full}});

  always_comb begin
    state_d   = state_q;
    hold_id_d = hold_id_q;
    gnt_v     = 1'b0;
    gnt_id    = hold_id_q;
    unique case (state_q)
      ARB: begin
        if (&elig) begin
          gnt_v  = 1'b1;
          gnt_id = ~last_q;
        end else if (elig[0]) begin
          gnt_v  = 1'b1;
          gnt_id = 1'b0;
        end else if (elig[1]) begin
          gnt_v  = 1'b1;
          gnt_id = 1'b1;
        end
      end
      HOLD: gnt_v = rd_v[hold_id_q] | wr_v[hold_id_q];
      default: ;
    endcase
    if (rst) begin
      gnt_v = 1'b0;
    end

    s_read_c  = gnt_v & rd_v[gnt_id] & ~fifo_full;
    s_write_c = gnt_v & wr_v[gnt_id];
    accept    = (s_read_c | s_write_c) & ~s_waitrequest;

    if ((s_read_c | s_write_c) & s_waitrequest) begin
      state_d   = HOLD;
      hold_id_d = gnt_id;
    end else begin
      state_d = ARB;
    end
  end

  assign last_d       = accept ? gnt_id : last_q;
  assign err_orphan_d = err_orphan_q | (s_readdatavalid & (pend == '0));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ARB;
      last_q       <= 1'b1;
      hold_id_q    <= 1'b0;
      err_orphan_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      hold_id_q    <= hold_id_d;
      err_orphan_q <= err_orphan_d;
    end
  end

  owner_fifo #(.DEPTH(MAX_PEND)) u_owner_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_i    (accept & s_read_c),
    .push_id_i (gnt_id),
    .pop_i     (s_readdatavalid),
    .head_o    (fifo_head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (pend)
  );

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      assign wait_v[gi] = ~(accept & (gnt_id == id_t'(gi)));
      assign rdv_v[gi]  = s_readdatavalid & ~fifo_empty & (fifo_head == id_t'(gi));
    end
  endgenerate

  assign s_read       = s_read_c;
  assign s_write      = s_write_c;
  assign s_address    = gnt_v ? addr_a[gnt_id]  : '0;
  assign s_writedata  = gnt_v ? wdata_a[gnt_id] : '0;
  assign s_byteenable = gnt_v ? be_a[gnt_id]    : '0;

  assign m0_waitrequest   = wait_v[0];
  assign m1_waitrequest   = wait_v[1];
  assign m0_readdata      = s_readdata;
  assign m1_readdata      = s_readdata;
  assign m0_readdatavalid = rdv_v[0];
  assign m1_readdatavalid = rdv_v[1];
  assign err_orphan       = err_orphan_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Randomised bench for sdram_port_arbiter: masters and controller are modelled here,
// a rule-level reference predicts grants, and a scoreboard checks read-data routing.
module tb_sdram_port_arbiter;

  localparam int AW = 24;
  localparam int DW = 16;
  localparam int BW = DW / 8;
  localparam int MP = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] m0_address, m1_address, s_address;
  logic          m0_read, m0_write, m1_read, m1_write;
  logic [DW-1:0] m0_writedata, m1_writedata, s_writedata;
  logic [BW-1:0] m0_byteenable, m1_byteenable, s_byteenable;
  logic          m0_waitrequest, m1_waitrequest;
  logic [DW-1:0] m0_readdata, m1_readdata, s_readdata;
  logic          m0_readdatavalid, m1_readdatavalid;
  logic          s_read, s_write, s_waitrequest, s_readdatavalid, err_orphan;

  always #5 clk = ~clk;

  sdram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_PEND(MP)) dut (
    .clk(clk), .rst(rst),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .m1_readdatavalid(m1_readdatavalid),
    .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_writedata(s_writedata), .s_byteenable(s_byteenable),
    .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
    .s_readdatavalid(s_readdatavalid), .err_orphan(err_orphan)
  );

  typedef struct {
    int            owner;
    logic [DW-1:0] data;
  } exp_t;

  int            errors = 0;
  int            checks = 0;
  exp_t          sb[$];
  logic [DW-1:0] ctrl_q[$];

  // Master command currently held by each master (held until accepted).
  bit            act[2], cr[2], cw[2];
  logic [AW-1:0] ca[2];
  logic [DW-1:0] cd[2];
  logic [BW-1:0] cb[2];

  // Reference state: who was served last, a stalled grant, reads in flight.
  int last_m, hold_v, hold_id, pend;
  bit orphan_m;

  int p_req[2], p_rd[2], p_wait, p_ret;
  bit stray;

  function automatic void chk(string name, logic [63:0] act_v, logic [63:0] exp_v);
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act_v, exp_v, $time);
    end
  endfunction

  task automatic model_reset();
    last_m = 1; hold_v = 0; hold_id = 0; pend = 0; orphan_m = 1'b0;
    sb.delete(); ctrl_q.delete();
    for (int n = 0; n < 2; n++) act[n] = 1'b0;
  endtask

  task automatic drive_masters();
    m0_address = ca[0]; m0_read = act[0] & cr[0]; m0_write = act[0] & cw[0];
    m0_writedata = cd[0]; m0_byteenable = cb[0];
    m1_address = ca[1]; m1_read = act[1] & cr[1]; m1_write = act[1] & cw[1];
    m1_writedata = cd[1]; m1_byteenable = cb[1];
  endtask

  task automatic do_reset(int n);
    @(posedge clk); #1;
    rst = 1'b1;
    m0_read = 1'b1; m1_write = 1'b1; m0_write = 1'b0; m1_read = 1'b0;
    s_waitrequest = 1'b0; s_readdatavalid = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #2;
      chk("rst_m0_wait", 64'(m0_waitrequest), 64'd1);
      chk("rst_m1_wait", 64'(m1_waitrequest), 64'd1);
      chk("rst_s_cmd", {62'd0, s_read, s_write}, 64'd0);
      chk("rst_err_orphan", 64'(err_orphan), 64'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    m0_read = 1'b0; m1_write = 1'b0;
    model_reset();
  endtask

  task automatic cycle();
    bit full, gv, e_rd, e_wr, acc;
    bit is_rd[2], is_wr[2], elig[2];
    int g;
    logic [DW-1:0] rdata;
    @(posedge clk); #1;
    s_readdatavalid = 1'b0;
    s_readdata = DW'($urandom);
    if (stray) begin
      s_readdatavalid = 1'b1;
    end else if (ctrl_q.size() > 0 && $urandom_range(99) < p_ret) begin
      s_readdatavalid = 1'b1;
      s_readdata = ctrl_q.pop_front();
    end
    for (int n = 0; n < 2; n++) begin
      if (!act[n] && $urandom_range(99) < p_req[n]) begin
        act[n] = 1'b1;
        cr[n] = ($urandom_range(99) < p_rd[n]);
        cw[n] = !cr[n];
        if ($urandom_range(99) < 3) begin
          cr[n] = 1'b1; cw[n] = 1'b1;
        end
        ca[n] = AW'($urandom);
        cd[n] = DW'($urandom);
        cb[n] = BW'($urandom);
      end
    end
    drive_masters();
    s_waitrequest = ($urandom_range(99) < p_wait);
    #1;
    full = (pend >= MP);
    for (int n = 0; n < 2; n++) begin
      is_wr[n] = act[n] & cw[n];
      is_rd[n] = act[n] & cr[n] & !cw[n];
      elig[n]  = is_wr[n] | (is_rd[n] & !full);
    end
    g = 0; gv = 1'b0;
    if (hold_v != 0) begin
      g = hold_id; gv = act[g];
    end else if (elig[0] && elig[1]) begin
      g = 1 - last_m; gv = 1'b1;
    end else if (elig[0] || elig[1]) begin
      g = elig[0] ? 0 : 1; gv = 1'b1;
    end
    e_rd = gv & is_rd[g] & !full;
    e_wr = gv & is_wr[g];
    acc  = (e_rd | e_wr) & !s_waitrequest;
    chk("s_read", 64'(s_read), 64'(e_rd));
    chk("s_write", 64'(s_write), 64'(e_wr));
    chk("s_address", 64'(s_address), gv ? 64'(ca[g]) : 64'd0);
    chk("s_writedata", 64'(s_writedata), gv ? 64'(cd[g]) : 64'd0);
    chk("s_byteenable", 64'(s_byteenable), gv ? 64'(cb[g]) : 64'd0);
    chk("m0_waitrequest", 64'(m0_waitrequest), 64'(!(acc && g == 0)));
    chk("m1_waitrequest", 64'(m1_waitrequest), 64'(!(acc && g == 1)));
    chk("err_orphan", 64'(err_orphan), 64'(orphan_m));
    if (s_readdatavalid && pend == 0) orphan_m = 1'b1;
    if (s_readdatavalid && pend > 0) pend--;
    if (acc) begin
      last_m = g;
      act[g] = 1'b0;
      if (e_rd) begin
        rdata = DW'($urandom);
        sb.push_back('{owner: g, data: rdata});
        ctrl_q.push_back(rdata);
        pend++;
      end
    end
    hold_v  = ((e_rd | e_wr) && s_waitrequest) ? 1 : 0;
    hold_id = g;
  endtask

  task automatic run_phase(int n, int pr0, int pr1, int prd0, int prd1, int pw, int pret);
    p_req[0] = pr0; p_req[1] = pr1; p_rd[0] = prd0; p_rd[1] = prd1;
    p_wait = pw; p_ret = pret;
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic drain();
    int budget;
    budget = 300;
    p_req[0] = 0; p_req[1] = 0; p_wait = 0; p_ret = 100;
    while ((pend > 0 || act[0] || act[1]) && budget > 0) begin
      cycle();
      budget--;
    end
    chk("drain_timeout", 64'(budget == 0), 64'd0);
  endtask

  // Scoreboard monitor: every routed return must match the oldest issued read.
  always @(negedge clk) begin
    if (rst === 1'b0 && (m0_readdatavalid || m1_readdatavalid)) begin
      exp_t e;
      if (m0_readdatavalid && m1_readdatavalid) begin
        checks++; errors++;
        $display("FAIL rdv_both: got 11 expected one-hot at %0t", $time);
      end else if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL rdv_unexpected: got m%0d valid expected none at %0t",
                 m1_readdatavalid ? 1 : 0, $time);
      end else begin
        e = sb.pop_front();
        chk("rd_owner", 64'(m1_readdatavalid ? 1 : 0), 64'(e.owner));
        chk("rd_data", 64'(m1_readdatavalid ? m1_readdata : m0_readdata), 64'(e.data));
        $display("read return -> m%0d data %04h", e.owner, e.data);
      end
    end
  end

  initial begin
    rst = 1'b1; stray = 1'b0;
    m0_address = '0; m0_read = 1'b0; m0_write = 1'b0; m0_writedata = '0; m0_byteenable = '0;
    m1_address = '0; m1_read = 1'b0; m1_write = 1'b0; m1_writedata = '0; m1_byteenable = '0;
    s_waitrequest = 1'b0; s_readdata = '0; s_readdatavalid = 1'b0;
    model_reset();
    do_reset(3);

    // Single m0 read to 0x000010, returned three cycles later.
    act[0] = 1'b1; cr[0] = 1'b1; cw[0] = 1'b0; ca[0] = 24'h000010; cd[0] = '0; cb[0] = 2'b11;
    run_phase(3, 0, 0, 0, 0, 0, 0);
    run_phase(3, 0, 0, 0, 0, 0, 100);

    // Contention, no stall: alternating grants, eight reads then drained in order.
    run_phase(8, 100, 100, 100, 100, 0, 0);
    drain();

    // Owner FIFO fills with m0 reads; m1 writes continue, then one return frees a slot.
    run_phase(24, 100, 100, 100, 0, 0, 0);
    run_phase(6, 100, 100, 100, 0, 0, 30);
    drain();

    // Back-to-back reads with returns every cycle exercise simultaneous push and pop.
    run_phase(20, 100, 100, 100, 100, 0, 100);
    drain();

    // Heavy controller stalls: grant must stay frozen while waitrequest is high.
    run_phase(40, 100, 100, 50, 0, 80, 50);
    run_phase(2000, 60, 60, 50, 50, 30, 40);
    drain();
    run_phase(2, 0, 0, 0, 0, 0, 0);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    // Stray return with nothing pending: no routing, sticky error until reset.
    stray = 1'b1;
    run_phase(1, 0, 0, 0, 0, 0, 0);
    stray = 1'b0;
    run_phase(5, 0, 0, 0, 0, 0, 0);
    do_reset(2);
    run_phase(3, 0, 0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sdram_port_arbiter.md
# sdram_port_arbiter

Two-master Avalon-MM round-robin arbiter that shares the single SDRAM controller slave between the DNN accelerator's memory master (m0) and the CPU/DMA data master (m1). It forwards one command per cycle, holds the grant while the controller stalls, and tracks pipelined read ownership in an ID FIFO so `readdata` returns to the correct master. It sits between the two masters and the SDRAM controller's slave port inside the accelerator system.

## Interface
Parameters:
- ADDR_W, 24, word address width toward the SDRAM controller
- DATA_W, 16, data width; byteenable width is DATA_W/8
- MAX_PEND, 8, maximum outstanding reads; power of two, ≥2

Ports (N ∈ {0,1}):
- clk  in  1  system clock; single clock domain
- rst  in  1  synchronous, active-high reset
- mN_address  in  ADDR_W  master N word address
- mN_read  in  1  master N read request
- mN_write  in  1  master N write request
- mN_writedata  in  DATA_W  master N write data
- mN_byteenable  in  DATA_W/8  master N byte enables
- mN_waitrequest  out  1  stall to master N
- mN_readdata  out  DATA_W  read data to master N
- mN_readdatavalid  out  1  read data valid for master N
- s_address  out  ADDR_W  to controller
- s_read / s_write  out  1  to controller
- s_writedata  out  DATA_W  to controller
- s_byteenable  out  DATA_W/8  to controller
- s_waitrequest  in  1  controller stall
- s_readdata  in  DATA_W  controller read data
- s_readdatavalid  in  1  controller read data valid
- err_orphan  out  1  sticky: readdatavalid arrived with no pending owner

## Operation
- Request: reqN = mN_read | mN_write. mN_read & mN_write together is illegal; the read is dropped, treated as write.
- State machine, two states:
  - ARB: winner = the only requester; if both request, the master that is not `last` (last accepted). Winner's command is driven combinationally onto s_*.
  - HOLD: entered when a winner's command is presented and s_waitrequest=1; grant frozen to that master until accepted. Returns to ARB on acceptance.
- Acceptance: (s_read|s_write) & !s_waitrequest. On acceptance `last` <= granted ID.
- Read gating: if pend == MAX_PEND, a granted read is not driven (s_read=0) and the master sees waitrequest=1; writes from the other master may still win arbitration in ARB. Full blocks reads even if a pop occurs that cycle.
- mN_waitrequest = !(granted_N & command accepted this cycle). Non-granted requesters always see 1.
- Owner FIFO (depth MAX_PEND, 1-bit entries): push granted ID on accepted read; pop on s_readdatavalid. Push and pop together: pend unchanged, FIFO ordered correctly.
- Return path: mN_readdata = s_readdata (broadcast); mN_readdatavalid = s_readdatavalid & !empty & (head == N).
- s_readdatavalid with empty FIFO: data dropped, err_orphan <= 1 (cleared only by rst).
- Idle outputs: s_read=s_write=0; s_address/s_writedata/s_byteenable = 0 when no grant.

## Timing
- Zero-cycle command path: request to s_* in the same cycle; acceptance visible to the master in the same cycle.
- Zero-cycle return path: s_readdatavalid to mN_readdatavalid combinational.
- Throughput: one command per cycle; alternating masters under contention at full rate.
- Reset values: state=ARB, last=1 (m0 wins first tie), pend=0, FIFO empty, err_orphan=0; all mN_waitrequest=1 while rst=1, s_read=s_write=0.
- Reset mid-operation: pending reads discarded; controller is reset concurrently. Stray readdatavalid after reset sets err_orphan.

## Structure
- Package `sdram_arb_pkg`: state enum {ARB, HOLD}, master ID typedef (1 bit), MAX_PEND default.
- Sub-module `owner_fifo` (synchronous ring buffer: push, pop, head, full, empty, count); arbiter top instantiates one.

## Test plan
- Single master: m0 reads addr 0x000010, controller returns 0xBEEF after 3 cycles → m0_readdatavalid=1 with 0xBEEF, m1_readdatavalid stays 0.
- Contention: both masters read every cycle, no stall → accepts alternate m0,m1,m0,…; 8 returns route in issue order.
- Stall hold: m1 write 0x1234 to 0x000020 with s_waitrequest=1 for 4 cycles while m0 requests → s_* stable on m1's command, m1 accepted on cycle 5, m0 granted next.
- Full: 8 reads outstanding, no returns → 9th read held (s_read=0); m1 write still issued; after one readdatavalid, next cycle read issues.
- Push/pop same cycle with pend=3 → pend stays 3; owner order preserved.
- Orphan: s_readdatavalid with empty FIFO → no mN_readdatavalid, err_orphan=1 until rst.
